// File: rtl/sumador_serial.sv
// Serial adder/subtractor: processes CHUNK bits per clock, LSB first, over N = BITS/CHUNK cycles.
// Status outputs (Resul/Cout/Ovf/Zero) update only when an operation completes.
module sumador_serial #(
  parameter int BITS  = 8,
  parameter int CHUNK = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
  input  logic [BITS-1:0] num1,
  input  logic [BITS-1:0] num2,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] Resul,
  output logic            Cout,
  output logic            Ovf,
  output logic            Zero
);

  localparam int N  = BITS / CHUNK;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [BITS-1:0] a_reg, b_reg, res_reg, res_next;
  logic            op_reg, carry_reg;
  logic [CW-1:0]   cnt_reg;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]  csum;
  logic            msb_cin;
  int              base;

  // Subtraction is num1 + ~num2 + 1; the +1 comes from the carry register preload.
  always_comb begin
    base     = int'(cnt_reg) * CHUNK;
    a_chunk  = a_reg[base +: CHUNK];
    b_chunk  = b_reg[base +: CHUNK] ^ {CHUNK{op_reg}};
    csum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
    res_next = res_reg;
    res_next[base +: CHUNK] = csum[CHUNK-1:0];
    // Carry into the top bit of this chunk, recovered from its sum bit.
    msb_cin  = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ csum[CHUNK-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      op_reg    <= 1'b0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Resul     <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= num1;
            b_reg     <= num2;
            op_reg    <= op;
            carry_reg <= op;
            cnt_reg   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          res_reg   <= res_next;
          carry_reg <= csum[CHUNK];
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(N - 1)) begin
            state <= DONE;
            Resul <= res_next;
            Cout  <= csum[CHUNK];
            Ovf   <= msb_cin ^ csum[CHUNK];
            Zero  <= (res_next == '0);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serial.sv
// Directed bench for sumador_serial: 8-bit with CHUNK=2 (u1) and CHUNK=8 (u2) sharing stimulus.
`timescale 1ns/1ps
module tb_sumador_serial;

  logic       clk = 1'b0;
  logic       rst, start, op;
  logic [7:0] num1, num2;
  logic       busy1, done1, cout1, ovf1, zero1;
  logic [7:0] res1;
  logic       busy2, done2, cout2, ovf2, zero2;
  logic [7:0] res2;

  int tests  = 0;
  int failed = 0;
  int de1, de2, bc1, dc1;

  always #5 clk = ~clk;

  sumador_serial #(.BITS(8), .CHUNK(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .num1(num1), .num2(num2),
    .busy(busy1), .done(done1), .Resul(res1), .Cout(cout1), .Ovf(ovf1), .Zero(zero1)
  );

  sumador_serial #(.BITS(8), .CHUNK(8)) u2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .num1(num1), .num2(num2),
    .busy(busy2), .done(done2), .Resul(res2), .Cout(cout2), .Ovf(ovf2), .Zero(zero2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue start so it is sampled on the next edge (edge 0), then scramble the
  // inputs and watch edges 1..8 for busy/done timing.
  task automatic run_op(input logic o, input logic [7:0] a, input logic [7:0] b);
    op = o; num1 = a; num2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; num1 = ~a; num2 = a ^ b; op = ~o;
    de1 = -1; de2 = -1; bc1 = 0; dc1 = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (busy1) bc1++;
      if (done1) begin
        dc1++;
        if (de1 < 0) de1 = k;
      end
      if (done2 && de2 < 0) de2 = k;
    end
    $display("[TB] op=%0b %02h,%02h -> res=%02h cout=%0b ovf=%0b zero=%0b done_edge=%0d",
             o, a, b, res1, cout1, ovf1, zero1, de1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; num1 = '0; num2 = '0;
    @(posedge clk); #1;
    chk("rst_busy",  busy1, 0);
    chk("rst_done",  done1, 0);
    chk("rst_resul", res1,  0);
    chk("rst_flags", {cout1, ovf1, zero1}, 0);
    chk("rst_u2",    {busy2, done2, res2, cout2, ovf2, zero2}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Start on the very first edge after reset release
    run_op(1'b0, 8'h5A, 8'h3C);
    chk("add1_res",  res1, 8'h96);
    chk("add1_cout", cout1, 0);
    chk("add1_ovf",  ovf1, 1);
    chk("add1_zero", zero1, 0);
    chk("add1_done_edge", de1, 5);
    chk("add1_busy_cycles", bc1, 5);
    chk("add1_done_pulses", dc1, 1);

    run_op(1'b0, 8'hFF, 8'h01);
    chk("add2_res",  res1, 8'h00);
    chk("add2_flags", {cout1, ovf1, zero1}, 3'b101);

    run_op(1'b1, 8'h10, 8'h20);
    chk("sub1_res",  res1, 8'hF0);
    chk("sub1_flags", {cout1, ovf1, zero1}, 3'b000);

    run_op(1'b1, 8'h80, 8'h01);
    chk("sub2_res",  res1, 8'h7F);
    chk("sub2_flags", {cout1, ovf1, zero1}, 3'b110);
    chk("sub2_u2_res", res2, 8'h7F);

    // start during RUN must be ignored; outputs hold until DONE
    op = 1'b0; num1 = 8'h01; num2 = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dc1 = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = 1'b1; num1 = 8'hAA; num2 = 8'h55; op = 1'b1;
      end
      if (k == 3) start = 1'b0;
      if (done1) dc1++;
      if (k < 4) begin
        chk("hold_res",   res1, 8'h7F);
        chk("hold_flags", {cout1, ovf1, zero1}, 3'b110);
      end
    end
    $display("[TB] restart-ignored op -> res=%02h done_pulses=%0d", res1, dc1);
    chk("ign_res", res1, 8'h02);
    chk("ign_flags", {cout1, ovf1, zero1}, 3'b000);
    chk("ign_done_pulses", dc1, 1);

    // Reset in the 2nd RUN cycle aborts with no done
    op = 1'b0; num1 = 8'h11; num2 = 8'h22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("abort_outputs", {busy1, done1, res1, cout1, ovf1, zero1}, 0);
    dc1 = 0;
    @(posedge clk); #1;
    if (done1) dc1++;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done1) dc1++;
    end
    $display("[TB] abort -> done_pulses=%0d", dc1);
    chk("abort_no_done", dc1, 0);

    @(posedge clk); #1;
    run_op(1'b0, 8'h03, 8'h04);
    chk("post_rst_res", res1, 8'h07);
    chk("post_rst_done_edge", de1, 5);

    // CHUNK=BITS: single RUN cycle
    run_op(1'b0, 8'h7F, 8'h01);
    chk("c8_res", res2, 8'h80);
    chk("c8_ovf", ovf2, 1);
    chk("c8_cout", cout2, 0);
    chk("c8_done_edge", de2, 2);
    chk("c2_same_res", res1, 8'h80);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
